// File: rtl/aprecv_dsp_pkg.sv
// Shared fixed-point helpers for the aprecv sample-pipeline filters.
// All helpers work on a 64-bit signed carrier and take the logical width as an argument.
package aprecv_dsp_pkg;

    localparam int unsigned WIDE_W = 32'd64;

    typedef logic signed [63:0] wide_t;

    typedef struct packed {
        logic  clipped;
        wide_t value;
    } sat_t;

    function automatic wide_t sext(input wide_t v, input int unsigned w);
        return (v <<< (WIDE_W - w)) >>> (WIDE_W - w);
    endfunction

    function automatic sat_t saturate(input wide_t v, input int unsigned w);
        wide_t max_v;
        wide_t min_v;
        sat_t  r;
        max_v = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (v > max_v) begin
            r.value   = max_v;
            r.clipped = 1'b1;
        end else if (v < min_v) begin
            r.value   = min_v;
            r.clipped = 1'b1;
        end else begin
            r.value   = v;
            r.clipped = 1'b0;
        end
        return r;
    endfunction

    // Round-half-up: the arithmetic shift floors, so negative halves round toward +inf.
    function automatic wide_t round_shift(input wide_t v, input int unsigned s);
        return (v + (64'sd1 <<< (s - 32'd1))) >>> s;
    endfunction

endpackage

// File: rtl/sat_round.sv
// Combinational round-half-up right shift followed by signed saturation.
module sat_round
    import aprecv_dsp_pkg::*;
#(
    parameter int unsigned IN_W  = 32'd41,
    parameter int unsigned OUT_W = 32'd12,
    parameter int unsigned SHIFT = 32'd15
) (
    input  logic signed [IN_W-1:0]  din_i,
    output logic signed [OUT_W-1:0] dout_o,
    output logic                    sat_o
);

    wide_t rounded_s;
    sat_t  clip_s;
    logic  unused_s;

    // Round, then clip into the output range.
    always_comb begin
        rounded_s = round_shift(wide_t'(din_i), SHIFT);
        clip_s    = saturate(rounded_s, OUT_W);
        dout_o    = clip_s.value[OUT_W-1:0];
        sat_o     = clip_s.clipped;
    end

    assign unused_s = ^clip_s.value[63:OUT_W];

endmodule

// File: rtl/integrate.sv
// Leaky saturating accumulator that rebuilds a signal from a derivative stream.
// Three stages: accumulate, scale by ~1/12, round/saturate.
module integrate
    import aprecv_dsp_pkg::*;
#(
    parameter int          INPUT_WIDTH  = 12,
    parameter int          OUTPUT_WIDTH = 12,
    parameter int          ACC_WIDTH    = 24,
    parameter int          LEAK_SHIFT   = 0,
    parameter int unsigned SCALE_NUM    = 32'd2731,
    parameter int unsigned SCALE_SHIFT  = 32'd15
) (
    input  logic                           clk,
    input  logic                           rst_ni,
    input  logic                           clken_i,
    input  logic                           dvalid_i,
    input  logic                           clear_i,
    input  logic signed [INPUT_WIDTH-1:0]  dx_i,
    output logic signed [OUTPUT_WIDTH-1:0] x_o,
    output logic                           dvalid_o,
    output logic                           sat_o,
    output logic                           ovf_o
);

    localparam int PROD_W = ACC_WIDTH + 17;
    localparam logic signed [16:0] SCALE_S = {1'b0, 16'(SCALE_NUM)};

    logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
    logic                           v1_q, v1_d;
    logic                           ovf_q, ovf_d;
    logic signed [PROD_W-1:0]       prod_q, prod_d;
    logic                           v2_q, v2_d;
    logic signed [OUTPUT_WIDTH-1:0] x_q, x_d;
    logic                           sat_q, sat_d;
    logic                           dvalid_q, dvalid_d;

    wide_t                          acc_w_s;
    wide_t                          leak_s;
    wide_t                          sum_s;
    sat_t                           acc_sat_s;
    logic signed [OUTPUT_WIDTH-1:0] sr_x_s;
    logic                           sr_sat_s;
    logic                           unused_s;

    sat_round #(
        .IN_W  (PROD_W),
        .OUT_W (OUTPUT_WIDTH),
        .SHIFT (SCALE_SHIFT)
    ) u_sat_round (
        .din_i  (prod_q),
        .dout_o (sr_x_s),
        .sat_o  (sr_sat_s)
    );

    // Stage-1 arithmetic: add the sample, subtract the leak, clip to the accumulator range.
    always_comb begin
        acc_w_s   = wide_t'(acc_q);
        leak_s    = (LEAK_SHIFT == 0) ? 64'sd0 : (acc_w_s >>> LEAK_SHIFT);
        sum_s     = acc_w_s + sext(wide_t'($unsigned(dx_i)), INPUT_WIDTH) - leak_s;
        acc_sat_s = saturate(sum_s, ACC_WIDTH);
    end

    assign unused_s = ^acc_sat_s.value[63:ACC_WIDTH];

    // Next-state for all pipeline registers; clear wins over a same-cycle sample.
    always_comb begin
        acc_d    = acc_q;
        v1_d     = v1_q;
        ovf_d    = ovf_q;
        prod_d   = prod_q;
        v2_d     = v2_q;
        x_d      = x_q;
        sat_d    = sat_q;
        dvalid_d = dvalid_q;
        if (clken_i) begin
            if (clear_i) begin
                acc_d    = '0;
                v1_d     = 1'b0;
                ovf_d    = 1'b0;
                prod_d   = '0;
                v2_d     = 1'b0;
                x_d      = '0;
                sat_d    = 1'b0;
                dvalid_d = 1'b0;
            end else begin
                if (dvalid_i) begin
                    acc_d = acc_sat_s.value[ACC_WIDTH-1:0];
                    ovf_d = ovf_q | acc_sat_s.clipped;
                end else begin
                    acc_d = acc_q;
                    ovf_d = ovf_q;
                end
                v1_d     = dvalid_i;
                prod_d   = PROD_W'(acc_q) * PROD_W'(SCALE_S);
                v2_d     = v1_q;
                dvalid_d = v2_q;
                if (v2_q) begin
                    x_d   = sr_x_s;
                    sat_d = sr_sat_s;
                end else begin
                    x_d   = x_q;
                    sat_d = sat_q;
                end
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q    <= '0;
            v1_q     <= 1'b0;
            ovf_q    <= 1'b0;
            prod_q   <= '0;
            v2_q     <= 1'b0;
            x_q      <= '0;
            sat_q    <= 1'b0;
            dvalid_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            v1_q     <= v1_d;
            ovf_q    <= ovf_d;
            prod_q   <= prod_d;
            v2_q     <= v2_d;
            x_q      <= x_d;
            sat_q    <= sat_d;
            dvalid_q <= dvalid_d;
        end
    end

    assign x_o      = x_q;
    assign dvalid_o = dvalid_q;
    assign sat_o    = sat_q;
    assign ovf_o    = ovf_q;

endmodule
